// File: rtl/pf_lanectrl_pause_seq.sv
// Lane-pause sequencer: round-robin shares one HS_IO_CLK_PAUSE among NUM_REQ
// requesters. Each sequence is PRE (pause held) -> ACT (grant) -> POST (pause
// held) -> ACKS (ack pulse, pause released) -> optional GAP -> IDLE.
module pf_lanectrl_pause_seq #(
  parameter int NUM_REQ        = 4,
  parameter int PRE_CYCLES     = 4,
  parameter int POST_CYCLES    = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [NUM_REQ-1:0] DONE,
  input  logic               ERR_CLR,
  output logic [NUM_REQ-1:0] GNT,
  output logic [NUM_REQ-1:0] ACK,
  output logic               HS_IO_CLK_PAUSE,
  output logic               BUSY,
  output logic               TIMEOUT_ERR
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACT, S_POST, S_ACKS, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [15:0]        ph_q, ph_d;
  logic [7:0]         act_q, act_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               pause_q, pause_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] arb_req;
  logic               arb_hit;
  logic [IDX_W-1:0]   arb_idx;

  // Round-robin pick starting after last_served. With no gap, arbitration also
  // runs on the ACKS edge; the requester being acked is masked because its
  // REQ may still be high during its ACK cycle.
  always_comb begin
    int k;
    k       = 0;
    arb_req = REQ;
    if (state_q == S_ACKS) arb_req[sel_q] = 1'b0;
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = (int'(last_q) + i) % NUM_REQ;
      if (arb_req[k]) begin
        arb_hit = 1'b1;
        arb_idx = IDX_W'(k);
      end
    end
  end

  // Sequencer next-state; outputs are derived from the next state so they
  // register cleanly with no decode glitches on the pause line.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    ph_d    = ph_q;
    act_d   = act_q;
    err_d   = err_q & ~ERR_CLR;
    case (state_q)
      S_IDLE: if (arb_hit) begin
        sel_d   = arb_idx;
        ph_d    = '0;
        state_d = S_PRE;
      end
      S_PRE: if (ph_q == 16'(PRE_CYCLES - 1)) begin
        act_d   = '0;
        state_d = S_ACT;
      end else ph_d = ph_q + 16'd1;
      S_ACT: if (DONE[sel_q]) begin
        ph_d    = '0;
        state_d = S_POST;
      end else if (act_q == 8'(TIMEOUT_CYCLES - 1)) begin
        ph_d    = '0;
        err_d   = 1'b1;   // set wins over a same-edge ERR_CLR
        state_d = S_POST;
      end else if (act_q != 8'hFF) act_d = act_q + 8'd1;
      S_POST: if (ph_q == 16'(POST_CYCLES - 1)) begin
        last_d  = sel_q;
        state_d = S_ACKS;
      end else ph_d = ph_q + 16'd1;
      S_ACKS: if (GAP_CYCLES == 0) begin
        if (arb_hit) begin
          sel_d   = arb_idx;
          ph_d    = '0;
          state_d = S_PRE;
        end else state_d = S_IDLE;
      end else begin
        ph_d    = '0;
        state_d = S_GAP;
      end
      S_GAP: if (ph_q == 16'(GAP_CYCLES - 1)) state_d = S_IDLE;
             else ph_d = ph_q + 16'd1;
      default: state_d = S_IDLE;
    endcase

    gnt_d = '0;
    ack_d = '0;
    if (state_d == S_ACT)  gnt_d[sel_d] = 1'b1;
    if (state_d == S_ACKS) ack_d[sel_d] = 1'b1;
    pause_d = (state_d == S_PRE) || (state_d == S_ACT) || (state_d == S_POST);
    busy_d  = (state_d != S_IDLE);
  end

  // State and registered outputs; reset overrides every other input.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      ph_q    <= '0;
      act_q   <= '0;
      err_q   <= 1'b0;
      gnt_q   <= '0;
      ack_q   <= '0;
      pause_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      ph_q    <= ph_d;
      act_q   <= act_d;
      err_q   <= err_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      pause_q <= pause_d;
      busy_q  <= busy_d;
    end
  end

  assign GNT             = gnt_q;
  assign ACK             = ack_q;
  assign HS_IO_CLK_PAUSE = pause_q;
  assign BUSY            = busy_q;
  assign TIMEOUT_ERR     = err_q;

endmodule

// File: tb/tb_pf_lanectrl_pause_seq.sv
// Random bench for two sequencer configurations (with gap / zero gap). The
// reference model tracks each sequence by its start and done edge numbers and
// derives every output from timing arithmetic.
module tb_pf_lanectrl_pause_seq;
  localparam int NR   = 4;
  localparam int NCYC = 5000;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [NR-1:0] req_v [2];
  logic [NR-1:0] done_v [2];
  logic          rst_v [2];
  logic          clr_v [2];
  logic [NR-1:0] gnt_o [2];
  logic [NR-1:0] ack_o [2];
  logic          pause_o [2];
  logic          busy_o [2];
  logic          err_o [2];

  pf_lanectrl_pause_seq #(.NUM_REQ(NR), .PRE_CYCLES(4), .POST_CYCLES(4),
                          .GAP_CYCLES(2), .TIMEOUT_CYCLES(8)) u_dut0 (
    .CLK(CLK), .RESET(rst_v[0]), .REQ(req_v[0]), .DONE(done_v[0]), .ERR_CLR(clr_v[0]),
    .GNT(gnt_o[0]), .ACK(ack_o[0]), .HS_IO_CLK_PAUSE(pause_o[0]), .BUSY(busy_o[0]),
    .TIMEOUT_ERR(err_o[0]));

  pf_lanectrl_pause_seq #(.NUM_REQ(NR), .PRE_CYCLES(1), .POST_CYCLES(1),
                          .GAP_CYCLES(0), .TIMEOUT_CYCLES(3)) u_dut1 (
    .CLK(CLK), .RESET(rst_v[1]), .REQ(req_v[1]), .DONE(done_v[1]), .ERR_CLR(clr_v[1]),
    .GNT(gnt_o[1]), .ACK(ack_o[1]), .HS_IO_CLK_PAUSE(pause_o[1]), .BUSY(busy_o[1]),
    .TIMEOUT_ERR(err_o[1]));

  function automatic int pre_of(int u);  return u ? 1 : 4; endfunction
  function automatic int post_of(int u); return u ? 1 : 4; endfunction
  function automatic int gap_of(int u);  return u ? 0 : 2; endfunction
  function automatic int to_of(int u);   return u ? 3 : 8; endfunction

  int total = 0;
  int bad   = 0;
  int n;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  // model state: a sequence = (selected requester, start edge, done edge)
  bit m_act [2];
  int m_sel [2];
  int m_ts  [2];
  int m_td  [2];   // -1 while still waiting for DONE/timeout
  int m_last[2];
  bit m_err [2];
  logic [NR-1:0] eg [2];
  logic [NR-1:0] ea [2];
  bit            ep [2];
  bit            eb [2];

  task automatic m_step(int u);
    int g, a, fe, pick;
    bit free, hit;
    logic [NR-1:0] r;
    a = 0;
    if (rst_v[u]) begin
      m_act[u] = 0; m_last[u] = NR - 1; m_err[u] = 0;
      return;
    end
    if (clr_v[u]) m_err[u] = 0;
    if (m_act[u]) begin
      g = m_ts[u] + pre_of(u);
      if (m_td[u] < 0 && n > g) begin
        if (done_v[u][m_sel[u]]) m_td[u] = n;
        else if (n - g == to_of(u)) begin m_td[u] = n; m_err[u] = 1; end
      end
      if (m_td[u] >= 0) begin
        a = m_td[u] + post_of(u);
        if (n == a) m_last[u] = m_sel[u];
      end
    end
    fe   = (gap_of(u) == 0) ? a + 1 : a + 2 + gap_of(u);
    free = !m_act[u] || (m_td[u] >= 0 && n >= fe);
    if (free) begin
      r = req_v[u];
      if (m_act[u] && gap_of(u) == 0 && n == a + 1) r[m_sel[u]] = 1'b0;
      hit = 0; pick = 0;
      for (int k = 1; k <= NR; k++) begin
        int idx;
        idx = (m_last[u] + k) % NR;
        if (r[idx] && !hit) begin hit = 1; pick = idx; end
      end
      if (hit) begin
        m_act[u] = 1; m_sel[u] = pick; m_ts[u] = n; m_td[u] = -1;
      end else m_act[u] = 0;
    end
  endtask

  task automatic m_out(int u);
    int g, a;
    eg[u] = '0; ea[u] = '0; ep[u] = 0; eb[u] = 0;
    if (!m_act[u]) return;
    g = m_ts[u] + pre_of(u);
    a = (m_td[u] >= 0) ? m_td[u] + post_of(u) : 0;
    ep[u] = (m_td[u] < 0) || (n < a);
    if (n >= g && (m_td[u] < 0 || n < m_td[u])) eg[u][m_sel[u]] = 1'b1;
    if (m_td[u] >= 0 && n == a) ea[u][m_sel[u]] = 1'b1;
    eb[u] = (m_td[u] < 0) || (n < a + 1 + gap_of(u));
  endtask

  logic [NR-1:0] pend [2];
  int  dcnt  [2];
  bit  gprev [2];

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_v[u] = 1; clr_v[u] = 0; req_v[u] = '0; done_v[u] = '0;
      pend[u] = '0; dcnt[u] = 0; gprev[u] = 0;
      m_act[u] = 0; m_last[u] = NR - 1; m_err[u] = 0; m_td[u] = -1; m_ts[u] = 0; m_sel[u] = 0;
    end
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge CLK);
      n = cyc;
      for (int u = 0; u < 2; u++) begin m_step(u); m_out(u); end
      @(negedge CLK);
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("gnt%0d", u),   32'(gnt_o[u]),   32'(eg[u]));
        chk($sformatf("ack%0d", u),   32'(ack_o[u]),   32'(ea[u]));
        chk($sformatf("pause%0d", u), 32'(pause_o[u]), 32'(ep[u]));
        chk($sformatf("busy%0d", u),  32'(busy_o[u]),  32'(eb[u]));
        chk($sformatf("terr%0d", u),  32'(err_o[u]),   32'(m_err[u]));
      end
      // next inputs
      for (int u = 0; u < 2; u++) begin
        logic [NR-1:0] noise;
        bit dbit;
        rst_v[u] = (cyc < 2) || ($urandom_range(0, 299) == 0);
        clr_v[u] = ($urandom_range(0, 19) == 0);
        for (int i = 0; i < NR; i++) begin
          if (ea[u][i]) pend[u][i] = 1'b0;
          else if (!pend[u][i] && $urandom_range(0, 5) == 0) pend[u][i] = 1'b1;
        end
        req_v[u] = pend[u];
        dbit = 0;
        if (eg[u] != '0) begin
          if (!gprev[u]) dcnt[u] = $urandom_range(0, to_of(u) + 2);
          dbit = (dcnt[u] == 0);
          if (dcnt[u] > 0) dcnt[u]--;
        end
        gprev[u] = (eg[u] != '0);
        noise = NR'($urandom_range(0, (1 << NR) - 1));
        if (eg[u] != '0) noise = noise & ~eg[u];
        if ($urandom_range(0, 3) != 0) noise = '0;
        done_v[u] = noise | (dbit ? eg[u] : '0);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pf_lanectrl_pause_seq.md
PF_LANECTRL_PAUSE_SEQ -- requirements
Module: pf_lanectrl_pause_seq

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing the lane pause (range 2..8).
REQ-002 Parameter PRE_CYCLES, default 4, SHALL set the cycles HS_IO_CLK_PAUSE is held before grant (min 1).
REQ-003 Parameter POST_CYCLES, default 4, SHALL set the cycles HS_IO_CLK_PAUSE is held after DONE (min 1).
REQ-004 Parameter GAP_CYCLES, default 2, SHALL set the idle cycles between sequences (0 allowed).
REQ-005 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum cycles spent in ACT (min 1, 8-bit counter).
REQ-006 CLK  input  1  single clock; all logic on its rising edge.
REQ-007 RESET  input  1  synchronous, active-high reset.
REQ-008 REQ  input  NUM_REQ  level request per requester, held until its ACK.
REQ-009 DONE  input  NUM_REQ  requester update complete; only sampled for the granted requester in ACT.
REQ-010 ERR_CLR  input  1  clears TIMEOUT_ERR.
REQ-011 GNT  output  NUM_REQ  one-hot grant, high for the whole ACT state.
REQ-012 ACK  output  NUM_REQ  one-cycle completion pulse to the served requester.
REQ-013 HS_IO_CLK_PAUSE  output  1  registered pause to the lane controller pause synchroniser.
REQ-014 BUSY  output  1  high whenever state is not IDLE.
REQ-015 TIMEOUT_ERR  output  1  sticky ACT-timeout flag.

Function
REQ-016 The FSM SHALL have states IDLE, PRE, ACT, POST, ACKS, GAP; all outputs registered.
REQ-017 IDLE: on any REQ bit high at an edge, the block SHALL latch the winner, go to PRE, and set HS_IO_CLK_PAUSE=1 and BUSY=1 from that edge.
REQ-018 Arbitration SHALL be round-robin: search starts at (last_served+1) mod NUM_REQ; last_served resets to NUM_REQ-1, so REQ[0] wins first.
REQ-019 REQ SHALL be sampled only in IDLE; REQ changes in other states SHALL not alter the current sequence.
REQ-020 PRE SHALL last exactly PRE_CYCLES cycles, then go to ACT with GNT[sel]=1.
REQ-021 ACT: an edge with DONE[sel]=1 SHALL move to POST and drop GNT; DONE on non-granted bits SHALL be ignored.
REQ-022 ACT: if DONE[sel] is not seen within TIMEOUT_CYCLES cycles, the block SHALL move to POST and set TIMEOUT_ERR.
REQ-023 POST SHALL last exactly POST_CYCLES cycles with HS_IO_CLK_PAUSE=1.
REQ-024 At POST exit, HS_IO_CLK_PAUSE SHALL fall and ACK[sel] SHALL rise on the same edge (state ACKS, one cycle), also after a timeout.
REQ-025 ACKS SHALL go to GAP for GAP_CYCLES cycles (BUSY=1, PAUSE=0), or directly to IDLE when GAP_CYCLES=0; last_served SHALL update to sel at ACKS.
REQ-026 Latency: REQ seen at edge t gives PAUSE high after t, GNT high after t+PRE_CYCLES; DONE seen at edge d gives ACK high after d+POST_CYCLES.
REQ-027 HS_IO_CLK_PAUSE SHALL be high continuously from PRE entry to ACKS entry, with no glitch.
REQ-028 TIMEOUT_ERR SHALL clear only on ERR_CLR; a set and ERR_CLR on the same edge SHALL leave it set.
REQ-029 The ACT cycle counter SHALL saturate and SHALL not wrap.
REQ-030 At most one GNT bit and one ACK bit SHALL be high in any cycle.

Reset
REQ-031 RESET high at an edge SHALL force state IDLE, last_served=NUM_REQ-1, counters 0, and GNT, ACK, HS_IO_CLK_PAUSE, BUSY and TIMEOUT_ERR all 0 from that edge.
REQ-032 Reset in mid-sequence SHALL abort it with no ACK; HS_IO_CLK_PAUSE SHALL be 0 after the reset edge.
REQ-033 RESET SHALL take priority over ERR_CLR and all other inputs.

Verification
REQ-034 Single request (defaults): REQ=0001 at edge 0, DONE[0] at edge 10 -> PAUSE 1 after edge 0, GNT=0001 after edge 4, GNT 0 after edge 10, PAUSE 0 and ACK=0001 after edge 14, BUSY 0 after edge 17.
REQ-035 Simultaneous requests: REQ=1111 held, each DONE 1 cycle after its GNT -> served order 0,1,2,3,0; one GNT at a time; each ACK 1 cycle wide.
REQ-036 Timeout: TIMEOUT_CYCLES=8, REQ=0100, DONE never asserted -> GNT=0100 held 8 cycles, TIMEOUT_ERR=1, ACK=0100 pulse; ERR_CLR then clears the flag.
REQ-037 Wrong DONE: GNT=0010, DONE=0001 pulsed -> state stays ACT, GNT unchanged.
REQ-038 Reset mid-ACT: GNT=0001, RESET pulsed 1 cycle -> all outputs 0 after that edge, no ACK; next REQ=0010 is served with PRE_CYCLES latency.
REQ-039 GAP_CYCLES=0 with back-to-back requests -> new PAUSE rises the edge after ACKS, giving exactly 1 cycle of PAUSE=0 between sequences.
